// File: rtl/cofre_pkg.sv
// Shared definitions for the safe's input conditioner: key FSM states,
// key index constants and the millisecond-to-clock-cycle helpers.
package cofre_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int unsigned KEY0 = 0;
    localparam int unsigned KEY1 = 1;

    function automatic int unsigned debounce_cycles(input int unsigned clk_hz,
                                                    input int unsigned debounce_ms);
        return clk_hz / 1000 * debounce_ms;
    endfunction

    function automatic int unsigned hold_cycles(input int unsigned clk_hz,
                                                input int unsigned hold_ms);
        return clk_hz / 1000 * hold_ms;
    endfunction

endpackage

// File: rtl/cofre_key_debounce.sv
// One pushbutton: 2-FF synchronizer plus debounce FSM producing a level and
// one-clock press/release pulses. Long-press pulse exists only with COFRE_LONGPRESS_EN.
module cofre_key_debounce
    import cofre_pkg::*;
#(
    parameter int unsigned D = 4
`ifdef COFRE_LONGPRESS_EN
    ,
    parameter int unsigned H = 10
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);

    localparam int CW = $clog2(D + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);

    logic          r_sync1;
    logic          r_sync2;
    key_state_t    r_state;
    key_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_press;
    logic          r_release;
    logic          w_press_nxt;
    logic          w_release_nxt;
    logic          w_p;

    // Sync flops preset to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign w_p       = ~r_sync2;
    assign w_cnt_inc = (r_cnt == CNT_LAST) ? r_cnt : r_cnt + 1'b1;

    // The entry clock counts as the first stable sample, so the commit happens
    // on the D-th stable sample; with D==1 the wait states are skipped entirely.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_p) begin
                    w_cnt_nxt = '0;
                    if (D == 1) begin
                        w_state_nxt = PRESSED;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_state_nxt = PRESS_WAIT;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!w_p) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            PRESSED: begin
                if (!w_p) begin
                    w_cnt_nxt = '0;
                    if (D == 1) begin
                        w_state_nxt   = IDLE;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_state_nxt = RELEASE_WAIT;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (w_p) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == CNT_LAST) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level   = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef COFRE_LONGPRESS_EN
    localparam int HW = $clog2(H + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(H - 1);
    localparam logic [HW-1:0] HOLD_DONE = HW'(H);

    logic [HW-1:0] r_hold_cnt;
    logic          r_hold;

    // Parking the counter at H keeps the hold pulse to one per press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= '0;
            r_hold     <= 1'b0;
        end else begin
            r_hold <= 1'b0;
            if ((r_state != PRESSED) || !w_p) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt == HOLD_LAST) begin
                r_hold     <= 1'b1;
                r_hold_cnt <= HOLD_DONE;
            end else if (r_hold_cnt != HOLD_DONE) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign o_hold = r_hold;
`else
    assign o_hold = 1'b0;
`endif

endmodule

// File: rtl/cofre_input_conditioner.sv
// Input conditioner for the safe: debounced pushbuttons with edge pulses and
// glitch-filtered switches. Define COFRE_LONGPRESS_EN to enable key_hold pulses.
module cofre_input_conditioner
    import cofre_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned NUM_KEYS    = 2,
    parameter int unsigned NUM_SW      = 8,
    parameter int unsigned SW_STABLE   = 4,
    parameter int unsigned HOLD_MS     = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_SW-1:0]   sw_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_SW-1:0]   sw_clean,
    output logic [NUM_KEYS-1:0] key_hold
);

    localparam int unsigned D = debounce_cycles(CLK_HZ, DEBOUNCE_MS);
`ifdef COFRE_LONGPRESS_EN
    localparam int unsigned H = hold_cycles(CLK_HZ, HOLD_MS);
`endif

    for (genvar k = 0; k < int'(NUM_KEYS); k++) begin : g_key
        cofre_key_debounce #(
            .D(D)
`ifdef COFRE_LONGPRESS_EN
            ,
            .H(H)
`endif
        ) u_key (
            .clk      (clk),
            .reset    (reset),
            .i_key_n  (key_raw[k]),
            .o_level  (key_level[k]),
            .o_press  (key_press[k]),
            .o_release(key_release[k]),
            .o_hold   (key_hold[k])
        );
    end

    localparam int SCW = $clog2(SW_STABLE + 1);
    localparam logic [SCW-1:0] SW_LAST = SCW'(SW_STABLE);

    logic [NUM_SW-1:0] r_sw_sync1;
    logic [NUM_SW-1:0] r_sw_sync2;
    logic [NUM_SW-1:0] r_sw_clean;
    logic [SCW-1:0]    r_sw_cnt [NUM_SW];

    // Each bit counts consecutive clocks of disagreement with its clean value;
    // any agreeing clock restarts the count, so short glitches never get through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
            r_sw_clean <= '0;
            for (int b = 0; b < int'(NUM_SW); b++) begin
                r_sw_cnt[b] <= '0;
            end
        end else begin
            r_sw_sync1 <= sw_raw;
            r_sw_sync2 <= r_sw_sync1;
            for (int b = 0; b < int'(NUM_SW); b++) begin
                if (r_sw_sync2[b] == r_sw_clean[b]) begin
                    r_sw_cnt[b] <= '0;
                end else if (r_sw_cnt[b] + 1'b1 == SW_LAST) begin
                    r_sw_clean[b] <= r_sw_sync2[b];
                    r_sw_cnt[b]   <= '0;
                end else begin
                    r_sw_cnt[b] <= r_sw_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign sw_clean = r_sw_clean;

endmodule

// File: tb/tb_cofre_input_conditioner.sv
// Directed bench for cofre_input_conditioner with D=4, SW_STABLE=4, H=10.
// The long-press scenario is exercised when COFRE_LONGPRESS_EN is defined.
module tb_cofre_input_conditioner;

    logic       clk;
    logic       reset;
    logic [1:0] key_raw;
    logic [7:0] sw_raw;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [7:0] sw_clean;
    logic [1:0] key_hold;

    int checks;
    int failures;

    cofre_input_conditioner #(
        .CLK_HZ     (1000),
        .DEBOUNCE_MS(4),
        .NUM_KEYS   (2),
        .NUM_SW     (8),
        .SW_STABLE  (4),
        .HOLD_MS    (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_raw    (key_raw),
        .sw_raw     (sw_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .sw_clean   (sw_clean),
        .key_hold   (key_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        key_raw = 2'b11;
        sw_raw  = 8'h00;
        tick(3);
        checks++;
        if ({key_level, key_press, key_release, key_hold} !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_keys: got %b expected 00000000",
                     {key_level, key_press, key_release, key_hold});
        end
        checks++;
        if (sw_clean !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_sw: got %h expected 00", sw_clean);
        end
        reset = 1'b1;
        tick(8);
        checks++;
        if ({key_level, key_press} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: got %b expected 0000", {key_level, key_press});
        end
    endtask

    task automatic test_press_latency();
        key_raw[1] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            checks++;
            if (key_press[1] !== (i == 6)) begin
                failures++;
                $display("[TB] FAIL press_latency clk %0d: got %b expected %b", i, key_press[1], (i == 6));
            end
            checks++;
            if (key_level[1] !== (i >= 6)) begin
                failures++;
                $display("[TB] FAIL press_level clk %0d: got %b expected %b", i, key_level[1], (i >= 6));
            end
        end
        checks++;
        if (key_press[0] !== 1'b0 || key_level[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL key0_idle: press %b level %b expected 0 0", key_press[0], key_level[0]);
        end
    endtask

    task automatic test_release();
        int rel_count;
        rel_count  = 0;
        key_raw[1] = 1'b1;
        tick(1);
        if (key_release[1] === 1'b1) rel_count++;
        tick(1);
        if (key_release[1] === 1'b1) rel_count++;
        tick(1);
        if (key_release[1] === 1'b1) rel_count++;
        key_raw[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (key_release[1] === 1'b1) rel_count++;
        end
        checks++;
        if (rel_count != 0) begin
            failures++;
            $display("[TB] FAIL release_bounce: got %0d pulses expected 0", rel_count);
        end
        checks++;
        if (key_level[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL level_after_bounce: got %b expected 1", key_level[1]);
        end
        key_raw[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            checks++;
            if (key_release[1] !== (i == 6)) begin
                failures++;
                $display("[TB] FAIL release_latency clk %0d: got %b expected %b", i, key_release[1], (i == 6));
            end
            checks++;
            if (key_level[1] !== (i < 6)) begin
                failures++;
                $display("[TB] FAIL release_level clk %0d: got %b expected %b", i, key_level[1], (i < 6));
            end
        end
    endtask

    task automatic test_press_bounce();
        int press_count;
        int press_at;
        press_count = 0;
        press_at    = -1;
        for (int i = 0; i < 32; i++) begin
            if (i < 20) key_raw[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            else        key_raw[1] = 1'b0;
            tick(1);
            if (key_press[1] === 1'b1) begin
                press_count++;
                press_at = i + 1;
            end
        end
        checks++;
        if (press_count != 1) begin
            failures++;
            $display("[TB] FAIL bounce_press_count: got %0d expected 1", press_count);
        end
        checks++;
        if (press_at != 26) begin
            failures++;
            $display("[TB] FAIL bounce_press_time: got clk %0d expected clk 26", press_at);
        end
        key_raw[1] = 1'b1;
        tick(10);
    endtask

    task automatic test_switch();
        sw_raw[4] = 1'b1;
        tick(1);
        sw_raw[4] = 1'b0;
        tick(8);
        checks++;
        if (sw_clean !== 8'h00) begin
            failures++;
            $display("[TB] FAIL sw_glitch: got %h expected 00", sw_clean);
        end
        sw_raw[4] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            checks++;
            if (sw_clean[4] !== (i >= 6)) begin
                failures++;
                $display("[TB] FAIL sw_latency clk %0d: got %b expected %b", i, sw_clean[4], (i >= 6));
            end
        end
        sw_raw = 8'h3C;
        tick(5);
        checks++;
        if (sw_clean !== 8'h10) begin
            failures++;
            $display("[TB] FAIL sw_bus_early: got %h expected 10", sw_clean);
        end
        tick(1);
        checks++;
        if (sw_clean !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL sw_bus: got %h expected 3c", sw_clean);
        end
        sw_raw = 8'h3D;
        tick(3);
        sw_raw = 8'h3C;
        tick(8);
        checks++;
        if (sw_clean !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL sw_short_pulse: got %h expected 3c", sw_clean);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int k1_press;
        k1_press   = 0;
        key_raw[1] = 1'b0;
        tick(8);
        key_raw[0] = 1'b0;
        tick(4);
        reset = 1'b0;
        #2;
        checks++;
        if ({key_level, key_press, key_release} !== 6'b000000 || sw_clean !== 8'h00) begin
            failures++;
            $display("[TB] FAIL async_reset: keys %b sw %h expected 000000 00",
                     {key_level, key_press, key_release}, sw_clean);
        end
        key_raw[1] = 1'b1;
        tick(3);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (key_press[1] === 1'b1) k1_press++;
            checks++;
            if (key_press[0] !== (i == 6)) begin
                failures++;
                $display("[TB] FAIL repress_after_reset clk %0d: got %b expected %b", i, key_press[0], (i == 6));
            end
        end
        checks++;
        if (k1_press != 0 || sw_clean !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL post_reset_state: key1 pulses %0d sw %h expected 0 3c", k1_press, sw_clean);
        end
        key_raw[0] = 1'b1;
        tick(10);
    endtask

    task automatic test_back_to_back();
        key_raw = 2'b00;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            checks++;
            if (key_press !== ((i == 6) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("[TB] FAIL dual_press clk %0d: got %b expected %b", i, key_press, ((i == 6) ? 2'b11 : 2'b00));
            end
        end
        key_raw = 2'b11;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            checks++;
            if (key_release !== ((i == 6) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("[TB] FAIL dual_release clk %0d: got %b expected %b", i, key_release, ((i == 6) ? 2'b11 : 2'b00));
            end
        end
    endtask

    task automatic test_hold();
        int press_at;
        int hold_at;
        int hold_count;
        press_at   = -1;
        hold_at    = -1;
        hold_count = 0;
        key_raw[1] = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            tick(1);
            if (key_press[1] === 1'b1) press_at = i;
            if (key_hold[1] === 1'b1) begin
                hold_count++;
                hold_at = i;
            end
        end
        checks++;
        if (press_at != 6) begin
            failures++;
            $display("[TB] FAIL hold_press_time: got clk %0d expected clk 6", press_at);
        end
`ifdef COFRE_LONGPRESS_EN
        checks++;
        if (hold_count != 1) begin
            failures++;
            $display("[TB] FAIL hold_count: got %0d expected 1", hold_count);
        end
        checks++;
        if (hold_at != 16) begin
            failures++;
            $display("[TB] FAIL hold_time: got clk %0d expected clk 16", hold_at);
        end
`else
        checks++;
        if (hold_count != 0) begin
            failures++;
            $display("[TB] FAIL hold_disabled: got %0d pulses (last clk %0d) expected 0", hold_count, hold_at);
        end
`endif
        key_raw[1] = 1'b1;
        tick(10);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_press_latency();
        test_release();
        test_press_bounce();
        test_switch();
        test_reset_mid_debounce();
        test_back_to_back();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
